program_loader: RTL and testbench

Upstream front-end for the programmable stack calculator. It accepts a byte stream over a valid/ready handshake and assembles it into 16-bit instruction words. Each word is written into the calculator's code memory through its `wr`/`addr`/`datain` port. When the program is loaded, the block pulses `start`, waits for the run to finish, and returns the calculator's `out` value to a downstream consumer.

---
 rtl/program_loader.sv | 182 ++++++++++++++++++
 tb/tb_program_loader.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader
//   Front-end for the programmable stack calculator. Collects a byte stream
//   (2-byte big-endian word count N, then N big-endian 16-bit words), writes
//   each word into the calculator code memory, pulses start, waits for the
//   run to finish and hands the calculator's top-of-stack value downstream.
//
// Ports
//   clk, nrst             clock, asynchronous active-low reset
//   in_data/in_valid      program byte stream in (in_ready = byte accepted)
//   mem_wr/addr/data      registered code-memory write port
//   start                 one-cycle run request to the calculator
//   calc_ready/calc_out   calculator idle flag and top-of-stack value
//   res_data/res_valid    captured result, held until res_ready
//   err                   one-cycle pulse: bad header or run timeout
module program_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_wr,
  output logic [9:0]  mem_addr,
  output logic [15:0] mem_data,
  output logic        start,
  input  logic        calc_ready,
  input  logic [15:0] calc_out,
  output logic [15:0] res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        err
);

  localparam logic [31:0] TO_LIMIT = TIMEOUT_CYCLES;

  typedef enum logic [3:0] {
    HDR_HI, HDR_LO, W_HI, W_LO, START, WAIT_BUSY, RUN, RESULT, DRAIN
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  n_hi;
  logic [7:0]  w_hi;
  logic [10:0] idx;
  logic [10:0] last_idx;
  logic [15:0] hdr_n;
  logic        armed;
  logic [31:0] cnt;
  logic        hdr_bad;
  logic        last_word;
  logic        timeout_hit;
  logic        issue_wr;
  logic        raise_err;
  logic        capture;

  assign hdr_n     = {n_hi, in_data};
  assign hdr_bad   = (hdr_n == 16'd0) || (hdr_n > 16'd1024);
  assign last_word = (idx == last_idx);
  // The run times out on the edge at which the counter would reach the limit.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((cnt + 32'd1) == TO_LIMIT);

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= HDR_HI;
    else       state <= state_nx;
  end

  // Next-state logic plus the combinational handshake outputs. start is
  // combinational so it can only ever be high while calc_ready is high.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    start     = 1'b0;
    issue_wr  = 1'b0;
    raise_err = 1'b0;
    capture   = 1'b0;
    case (state)
      HDR_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = HDR_LO;
      end
      HDR_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (hdr_bad) begin
            raise_err = 1'b1;
            state_nx  = HDR_HI;
          end else begin
            state_nx = W_HI;
          end
        end
      end
      W_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = W_LO;
      end
      W_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          issue_wr = 1'b1;
          state_nx = last_word ? START : W_HI;
        end
      end
      // armed is low in the first START cycle, which is the cycle carrying
      // the final mem_wr, so the write lands before start is sampled.
      START: begin
        if (armed && calc_ready) begin
          start    = 1'b1;
          state_nx = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (timeout_hit) begin
          raise_err = 1'b1;
          state_nx  = DRAIN;
        end else if (!calc_ready) begin
          state_nx = RUN;
        end
      end
      // A completion seen in the same cycle as the timeout still wins.
      RUN: begin
        if (calc_ready) begin
          capture  = 1'b1;
          state_nx = RESULT;
        end else if (timeout_hit) begin
          raise_err = 1'b1;
          state_nx  = DRAIN;
        end
      end
      RESULT: begin
        if (res_ready) state_nx = HDR_HI;
      end
      DRAIN: begin
        if (calc_ready) state_nx = HDR_HI;
      end
      default: state_nx = HDR_HI;
    endcase
  end

  // Datapath: header/word assembly, registered write port, run timer and
  // result holding register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      n_hi      <= 8'd0;
      w_hi      <= 8'd0;
      idx       <= 11'd0;
      last_idx  <= 11'd0;
      armed     <= 1'b0;
      cnt       <= 32'd0;
      mem_wr    <= 1'b0;
      mem_addr  <= 10'd0;
      mem_data  <= 16'd0;
      res_data  <= 16'd0;
      res_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_wr <= issue_wr;
      err    <= raise_err;
      armed  <= (state == START);
      if (state == HDR_HI && in_valid) n_hi <= in_data;
      if (state == HDR_LO && in_valid) begin
        last_idx <= hdr_n[10:0] - 11'd1;
        idx      <= 11'd0;
      end
      if (state == W_HI && in_valid) w_hi <= in_data;
      if (issue_wr) begin
        mem_addr <= idx[9:0];
        mem_data <= {w_hi, in_data};
        idx      <= idx + 11'd1;
      end
      if (start) cnt <= 32'd0;
      else if (state == WAIT_BUSY || state == RUN) cnt <= cnt + 32'd1;
      if (capture) begin
        res_data  <= calc_out;
        res_valid <= 1'b1;
      end else if (state == RESULT && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//   Directed self-checking bench for program_loader. A small behavioural
//   calculator model answers start pulses; a negedge monitor logs writes,
//   start and err pulses so each test task can compare against its own
//   hand-computed expectations.
module tb_program_loader;

  localparam int unsigned TB_TIMEOUT = 16;

  logic        clk;
  logic        nrst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_wr;
  logic [9:0]  mem_addr;
  logic [15:0] mem_data;
  logic        start;
  logic        calc_ready;
  logic [15:0] calc_out;
  logic [15:0] res_data;
  logic        res_valid;
  logic        res_ready;
  logic        err;

  int checks = 0;
  int errors = 0;

  bit          calc_hang   = 1'b0;
  int          busy_len    = 4;
  logic [15:0] calc_result = 16'h0000;

  int          cyc = 0;
  logic [9:0]  wr_addr [0:2047];
  logic [15:0] wr_data [0:2047];
  int          wr_cyc  [0:2047];
  int          wr_count      = 0;
  int          start_count   = 0;
  int          start_cyc     = 0;
  int          err_count     = 0;
  int          err_cyc       = 0;
  int          res_rise      = 0;
  int          overlap_count = 0;
  logic        res_valid_d   = 1'b0;

  program_loader #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .nrst(nrst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
    .start(start), .calc_ready(calc_ready), .calc_out(calc_out),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mem_wr === 1'b1) begin
      if (wr_count < 2048) begin
        wr_addr[wr_count] = mem_addr;
        wr_data[wr_count] = mem_data;
        wr_cyc[wr_count]  = cyc;
      end
      wr_count++;
    end
    if (start === 1'b1) begin
      start_count++;
      start_cyc = cyc;
    end
    if (err === 1'b1) begin
      err_count++;
      err_cyc = cyc;
      if (start === 1'b1 || mem_wr === 1'b1) overlap_count++;
    end
    if (res_valid === 1'b1 && res_valid_d !== 1'b1) res_rise++;
    res_valid_d = res_valid;
  end

  // Calculator model: drops ready on the edge that samples start, stays busy
  // for busy_len cycles (or until calc_hang is released), then returns out.
  initial begin
    calc_ready = 1'b1;
    calc_out   = 16'h0000;
    forever begin
      @(negedge clk);
      if (start === 1'b1 && calc_ready === 1'b1) begin
        @(posedge clk);
        #1 calc_ready = 1'b0;
        if (calc_hang) begin
          wait (calc_hang == 1'b0);
          @(posedge clk);
        end else begin
          repeat (busy_len) @(posedge clk);
        end
        #1;
        calc_out   = calc_result;
        calc_ready = 1'b1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    guard    = 0;
    while (in_ready !== 1'b1 && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 3000) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_byte: in_ready stuck at %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic wait_res(input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (res_valid !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_res: res_valid=%b after %0d cycles, required 1", res_valid, limit);
    end
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic test_reset();
    int b;
    // Power-on reset values.
    #2;
    checks++;
    if ({in_ready, mem_wr, mem_addr, mem_data, start, res_valid, res_data, err} !==
        {1'b1, 1'b0, 10'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_initial: rdy=%b wr=%b a=%h d=%h st=%b rv=%b rd=%h err=%b, required 1 0 000 0000 0 0 0000 0",
               in_ready, mem_wr, mem_addr, mem_data, start, res_valid, res_data, err);
    end
    @(posedge clk);
    #1 nrst = 1'b1;
    // Mid-stream reset after one word has been written.
    send_word(16'h0003, 0);
    send_word(16'h0005, 0);
    send_byte(8'h00, 0);
    nrst = 1'b0;
    #2;
    checks++;
    if ({in_ready, mem_wr, mem_addr, mem_data, start, res_valid, res_data, err} !==
        {1'b1, 1'b0, 10'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_midstream: rdy=%b wr=%b a=%h d=%h st=%b rv=%b rd=%h err=%b, required 1 0 000 0000 0 0 0000 0",
               in_ready, mem_wr, mem_addr, mem_data, start, res_valid, res_data, err);
    end
    @(posedge clk);
    #1 nrst = 1'b1;
    b = wr_count;
    calc_result = 16'h0042;
    send_word(16'h0001, 0);
    send_word(16'h1234, 0);
    wait_res(100);
    checks++;
    if (wr_count - b !== 1) begin
      errors++;
      $display("[TB] FAIL reset_wr_count: got %0d, required 1", wr_count - b);
    end
    checks++;
    if (wr_addr[b] !== 10'd0 || wr_data[b] !== 16'h1234) begin
      errors++;
      $display("[TB] FAIL reset_first_write: addr=%0d data=%h, required 0 1234", wr_addr[b], wr_data[b]);
    end
    checks++;
    if (res_data !== 16'h0042) begin
      errors++;
      $display("[TB] FAIL reset_result: got %h, required 0042", res_data);
    end
    release_res();
  endtask

  task automatic test_normal();
    int b, s;
    b = wr_count;
    s = start_count;
    busy_len    = 4;
    calc_result = 16'h000C;
    send_word(16'h0003, 0);
    send_word(16'h0005, 0);
    send_word(16'h0007, 0);
    send_word(16'hC000, 0);
    wait_res(100);
    checks++;
    if (wr_count - b !== 3) begin
      errors++;
      $display("[TB] FAIL normal_wr_count: got %0d, required 3", wr_count - b);
    end
    checks++;
    if (wr_addr[b] !== 10'd0 || wr_addr[b+1] !== 10'd1 || wr_addr[b+2] !== 10'd2) begin
      errors++;
      $display("[TB] FAIL normal_addr: got %0d %0d %0d, required 0 1 2", wr_addr[b], wr_addr[b+1], wr_addr[b+2]);
    end
    checks++;
    if (wr_data[b] !== 16'h0005 || wr_data[b+1] !== 16'h0007 || wr_data[b+2] !== 16'hC000) begin
      errors++;
      $display("[TB] FAIL normal_data: got %h %h %h, required 0005 0007 C000", wr_data[b], wr_data[b+1], wr_data[b+2]);
    end
    checks++;
    if (start_count - s !== 1) begin
      errors++;
      $display("[TB] FAIL normal_start_count: got %0d, required 1", start_count - s);
    end
    checks++;
    if (start_cyc <= wr_cyc[b+2]) begin
      errors++;
      $display("[TB] FAIL normal_start_after_write: start cycle %0d, last write cycle %0d, required later", start_cyc, wr_cyc[b+2]);
    end
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'h000C) begin
      errors++;
      $display("[TB] FAIL normal_result: valid=%b data=%h, required 1 000C", res_valid, res_data);
    end
    release_res();
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL normal_handoff: res_valid=%b in_ready=%b, required 0 1", res_valid, in_ready);
    end
  endtask

  task automatic test_bad_header();
    int b, e;
    b = wr_count;
    e = err_count;
    send_word(16'h0000, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (err_count - e !== 1 || wr_count !== b) begin
      errors++;
      $display("[TB] FAIL bad_hdr_zero: err pulses=%0d writes=%0d, required 1 0", err_count - e, wr_count - b);
    end
    send_word(16'h0401, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (err_count - e !== 2 || wr_count !== b) begin
      errors++;
      $display("[TB] FAIL bad_hdr_1025: err pulses=%0d writes=%0d, required 2 0", err_count - e, wr_count - b);
    end
    calc_result = 16'h0077;
    send_word(16'h0001, 0);
    send_word(16'hABCD, 0);
    wait_res(100);
    checks++;
    if (wr_count - b !== 1 || wr_addr[b] !== 10'd0 || wr_data[b] !== 16'hABCD) begin
      errors++;
      $display("[TB] FAIL bad_hdr_recover_write: n=%0d addr=%0d data=%h, required 1 0 ABCD", wr_count - b, wr_addr[b], wr_data[b]);
    end
    checks++;
    if (res_data !== 16'h0077) begin
      errors++;
      $display("[TB] FAIL bad_hdr_recover_result: got %h, required 0077", res_data);
    end
    release_res();
  endtask

  task automatic test_backpressure();
    int b;
    b = wr_count;
    calc_result = 16'h000C;
    send_word(16'h0003, $urandom_range(0, 3));
    send_word(16'h0005, $urandom_range(0, 3));
    send_word(16'h0007, $urandom_range(0, 3));
    send_word(16'hC000, $urandom_range(0, 3));
    wait_res(100);
    checks++;
    if (wr_count - b !== 3 ||
        wr_addr[b] !== 10'd0 || wr_addr[b+1] !== 10'd1 || wr_addr[b+2] !== 10'd2 ||
        wr_data[b] !== 16'h0005 || wr_data[b+1] !== 16'h0007 || wr_data[b+2] !== 16'hC000) begin
      errors++;
      $display("[TB] FAIL bp_writes: n=%0d a=%0d/%0d/%0d d=%h/%h/%h, required 3 0/1/2 0005/0007/C000",
               wr_count - b, wr_addr[b], wr_addr[b+1], wr_addr[b+2], wr_data[b], wr_data[b+1], wr_data[b+2]);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== 16'h000C || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle %0d: valid=%b data=%h in_ready=%b, required 1 000C 0", i, res_valid, res_data, in_ready);
      end
    end
    release_res();
    checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release: in_ready=%b res_valid=%b, required 1 0", in_ready, res_valid);
    end
  endtask

  task automatic test_timeout();
    int e, s, r, n;
    e = err_count;
    s = start_count;
    r = res_rise;
    calc_hang = 1'b1;
    send_word(16'h0001, 0);
    send_word(16'h0001, 0);
    n = 0;
    while (err_count == e && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (err_count - e !== 1) begin
      errors++;
      $display("[TB] FAIL timeout_err: pulses=%0d, required 1", err_count - e);
    end
    // err rises on the 16th clock edge after the edge that sampled start,
    // so it is observed 17 monitor cycles after the start cycle.
    checks++;
    if (err_cyc - start_cyc !== 17 || start_count - s !== 1) begin
      errors++;
      $display("[TB] FAIL timeout_delay: err-start=%0d starts=%0d, required 17 1", err_cyc - start_cyc, start_count - s);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL timeout_drain cycle %0d: in_ready=%b, required 0", i, in_ready);
      end
    end
    calc_hang = 1'b0;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1 || calc_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_recover: in_ready=%b calc_ready=%b, required 1 1", in_ready, calc_ready);
    end
    checks++;
    if (res_rise !== r || res_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_no_result: rises=%0d res_valid=%b, required 0 0", res_rise - r, res_valid);
    end
    checks++;
    if (overlap_count !== 0) begin
      errors++;
      $display("[TB] FAIL err_overlap: got %0d, required 0", overlap_count);
    end
  endtask

  task automatic test_max_program();
    int b, s, bad_a, bad_d;
    logic [15:0] w;
    b = wr_count;
    s = start_count;
    busy_len    = 2;
    calc_result = 16'h0400;
    send_word(16'h0400, 0);
    for (int i = 0; i < 1024; i++) begin
      w = 16'(i) ^ 16'h5A00;
      send_word(w, 0);
    end
    wait_res(100);
    checks++;
    if (wr_count - b !== 1024) begin
      errors++;
      $display("[TB] FAIL max_wr_count: got %0d, required 1024", wr_count - b);
    end
    bad_a = 0;
    bad_d = 0;
    for (int i = 0; i < 1024 && b + i < 2048; i++) begin
      w = 16'(i) ^ 16'h5A00;
      if (wr_addr[b+i] !== 10'(i)) bad_a++;
      if (wr_data[b+i] !== w) bad_d++;
    end
    checks++;
    if (bad_a !== 0 || bad_d !== 0) begin
      errors++;
      $display("[TB] FAIL max_contents: bad addresses=%0d bad data=%0d, required 0 0", bad_a, bad_d);
    end
    checks++;
    if (start_count - s !== 1 || b + 1023 >= 2048 || start_cyc <= wr_cyc[b+1023]) begin
      errors++;
      $display("[TB] FAIL max_start: starts=%0d start cycle=%0d, required 1 after last write", start_count - s, start_cyc);
    end
    checks++;
    if (res_data !== 16'h0400) begin
      errors++;
      $display("[TB] FAIL max_result: got %h, required 0400", res_data);
    end
    release_res();
  endtask

  initial begin
    nrst      = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    test_reset();
    test_normal();
    test_bad_header();
    test_backpressure();
    test_timeout();
    test_max_program();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
